// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a valid/ready handshake.
// Single-cycle logical/LUI/arithmetic ops; shifts step one bit per cycle
// through the result register to keep the critical path short.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic             shift_dir,
  input  logic             shift_ari,
  input  logic             do_unsigned,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] OP_NOP = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2,
                         OP_XOR = 4'd3, OP_NOR = 4'd4, OP_LUI = 4'd5,
                         OP_SH  = 4'd6, OP_ADD = 4'd7, OP_SUB = 4'd8,
                         OP_SLT = 4'd9;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_cnt;
  logic             r_dir;
  logic             r_ari;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_ov;
  logic             w_ill;
  logic [WIDTH-1:0] w_shift;

  assign w_sum  = src_a + src_b;
  assign w_diff = src_a - src_b;
  assign w_lt   = do_unsigned ? (src_a < src_b) : ($signed(src_a) < $signed(src_b));

  // One-bit step of the serial shifter; right shifts fill with MSB only when arithmetic.
  assign w_shift = r_dir ? {r_ari & r_result[WIDTH-1], r_result[WIDTH-1:1]}
                         : {r_result[WIDTH-2:0], 1'b0};

  // Single-cycle result and flags for the command presented at the input.
  always_comb begin
    w_res = '0;
    w_ov  = 1'b0;
    w_ill = 1'b0;
    case (ALU_control)
      OP_NOP: w_res = '0;
      OP_AND: w_res = src_a & src_b;
      OP_OR:  w_res = src_a | src_b;
      OP_XOR: w_res = src_a ^ src_b;
      OP_NOR: w_res = ~(src_a | src_b);
      OP_LUI: w_res = {src_b[15:0], {(WIDTH-16){1'b0}}};
      OP_SH:  w_res = src_b;
      OP_ADD: begin
        w_res = w_sum;
        w_ov  = !do_unsigned && (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ov  = !do_unsigned && (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_ill = 1'b1;
    endcase
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_ari       <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_result   <= w_res;
          r_zero     <= (w_res == '0);
          r_overflow <= w_ov;
          r_illegal  <= w_ill;
          r_dir      <= shift_dir;
          r_ari      <= shift_ari;
          if (ALU_control == OP_SH && shamt != 5'd0) begin
            r_cnt   <= shamt;
            r_state <= S_SHIFT;
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_SHIFT: begin
          r_result <= w_shift;
          r_zero   <= (w_shift == '0);
          r_cnt    <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors, latency and handshake checks.
module tb_alu_exec;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_control;
  logic        shift_dir;
  logic        shift_ari;
  logic        do_unsigned;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_control(ALU_control), .shift_dir(shift_dir), .shift_ari(shift_ari),
    .do_unsigned(do_unsigned), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .zero(zero), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a command for one accept edge, then wait (bounded) for out_valid.
  // lat = edges after the accept edge until out_valid; rdy = in_ready seen while busy.
  task automatic run(input logic [3:0] op, input logic dir, input logic ari,
                     input logic uns, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, output int lat, output logic rdy);
    @(negedge clk);
    ALU_control = op; shift_dir = dir; shift_ari = ari; do_unsigned = uns;
    src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    rdy = 1'b0;
    while (!out_valid && lat < 64) begin
      rdy = rdy | in_ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy = rdy | in_ready;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int   lat;
  logic rdy;
  logic stable;
  logic seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALU_control = 4'd0;
    shift_dir = 1'b0; shift_ari = 1'b0; do_unsigned = 1'b0;
    src_a = '0; src_b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    // add with signed overflow
    run(4'd7, 0, 0, 0, 32'h7FFFFFFF, 32'h1, 5'd0, lat, rdy);
    check("add_lat", lat, 0);
    check("add_res", result, 32'h80000000);
    check("add_ov", {31'b0, overflow}, 32'd1);
    check("add_zero", {31'b0, zero}, 32'd0);
    check("done_in_ready", {31'b0, in_ready}, 32'd0);
    take();
    check("take_out_valid", {31'b0, out_valid}, 32'd0);
    check("take_in_ready", {31'b0, in_ready}, 32'd1);

    run(4'd7, 0, 0, 1, 32'h7FFFFFFF, 32'h1, 5'd0, lat, rdy);
    check("addu_ov", {31'b0, overflow}, 32'd0);
    take();

    run(4'd8, 0, 0, 0, 32'h80000000, 32'h1, 5'd0, lat, rdy);
    check("sub_ov_res", result, 32'h7FFFFFFF);
    check("sub_ov", {31'b0, overflow}, 32'd1);
    take();

    run(4'd8, 0, 0, 0, 32'h12345678, 32'h12345678, 5'd0, lat, rdy);
    check("sub0_res", result, 32'h0);
    check("sub0_zero", {31'b0, zero}, 32'd1);
    check("sub0_ov", {31'b0, overflow}, 32'd0);
    take();

    run(4'd9, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 5'd0, lat, rdy);
    check("slt_s", result, 32'h1);
    take();
    run(4'd9, 0, 0, 1, 32'hFFFFFFFF, 32'h1, 5'd0, lat, rdy);
    check("slt_u", result, 32'h0);
    take();

    // logical ops
    run(4'd1, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat, rdy);
    check("and", result, 32'hF000F000); take();
    run(4'd2, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat, rdy);
    check("or", result, 32'hFFF0FFF0); take();
    run(4'd3, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat, rdy);
    check("xor", result, 32'h0FF00FF0); take();
    run(4'd4, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat, rdy);
    check("nor", result, 32'h000F000F); take();
    run(4'd0, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat, rdy);
    check("nop_res", result, 32'h0);
    check("nop_zero", {31'b0, zero}, 32'd1); take();

    // shifts
    run(4'd6, 1, 1, 0, 32'h0, 32'h80000000, 5'd4, lat, rdy);
    check("sra_lat", lat, 4);
    check("sra_res", result, 32'hF8000000);
    check("sra_busy_rdy", {31'b0, rdy}, 32'd0);
    take();
    run(4'd6, 1, 0, 0, 32'h0, 32'h80000000, 5'd4, lat, rdy);
    check("srl_res", result, 32'h08000000); take();
    run(4'd6, 0, 1, 0, 32'h0, 32'h1, 5'd31, lat, rdy);
    check("sll31_lat", lat, 31);
    check("sll31_res", result, 32'h80000000);
    check("sll31_zero", {31'b0, zero}, 32'd0); take();
    run(4'd6, 1, 0, 0, 32'h0, 32'hDEADBEEF, 5'd0, lat, rdy);
    check("sh0_lat", lat, 0);
    check("sh0_res", result, 32'hDEADBEEF); take();
    run(4'd6, 1, 0, 0, 32'h0, 32'h1, 5'd1, lat, rdy);
    check("srl_to0_res", result, 32'h0);
    check("srl_to0_zero", {31'b0, zero}, 32'd1); take();

    // backpressure on LUI, with a competing command offered during DONE
    run(4'd5, 0, 0, 0, 32'h0, 32'h0000ABCD, 5'd0, lat, rdy);
    check("lui_res", result, 32'hABCD0000);
    stable = 1'b1;
    @(negedge clk);
    ALU_control = 4'd7; src_a = 32'h1; src_b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== 32'hABCD0000 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("lui_hold", {31'b0, stable}, 32'd1);
    take();

    run(4'd12, 0, 0, 0, 32'h5, 32'h7, 5'd0, lat, rdy);
    check("ill_res", result, 32'h0);
    check("ill_flag", {31'b0, illegal}, 32'd1);
    take();
    run(4'd7, 0, 0, 0, 32'h2, 32'h3, 5'd0, lat, rdy);
    check("ill_clear", {31'b0, illegal}, 32'd0);
    check("add_small", result, 32'h5);
    take();

    // reset in the middle of a long shift
    @(negedge clk);
    ALU_control = 4'd6; shift_dir = 1'b0; src_b = 32'h3; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_result", result, 32'h0);
    check("mrst_flags", {29'b0, overflow, zero, illegal}, 32'd0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("mrst_no_valid", {31'b0, seen}, 32'd0);

    run(4'd2, 0, 0, 0, 32'h00FF0000, 32'h000000FF, 5'd0, lat, rdy);
    check("post_rst_or", result, 32'h00FF00FF);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle ALU execution unit for the datapath's execute stage. It accepts the 4-bit `ALU_control` code and the decoded shift/signedness qualifiers from the ALU decoder, together with the two operands. It returns a registered result under a valid/ready handshake. Logical, LUI and arithmetic ops complete in one cycle. Shifts use a 1-bit-per-cycle serial shifter, which keeps the critical path short on the FPGA target.

## Interface
- `WIDTH`, 32: datapath width; must be 32 (shamt is 5 bits).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  unit can accept a command; high only in IDLE.
- `ALU_control`  in  4  op code: 0 nop, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 LUI, 6 shift, 7 add, 8 sub, 9 set-less-than; 10–15 illegal.
- `shift_dir`  in  1  1 = right shift.
- `shift_ari`  in  1  1 = arithmetic (sign-filling) right shift; ignored for left shifts.
- `do_unsigned`  in  1  1 = no overflow detection for add/sub; unsigned compare for op 9.
- `src_a`  in  WIDTH  operand A (rs).
- `src_b`  in  WIDTH  operand B (rt or extended immediate); this is the shifted operand.
- `shamt`  in  5  shift amount.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  registered result.
- `overflow`  out  1  signed overflow on add/sub with `do_unsigned`=0.
- `zero`  out  1  `result` == 0.
- `illegal`  out  1  `ALU_control` was 10–15.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: all inputs are captured.
  - Op ≠ 6: compute, load `result` and flags, go to DONE.
  - Op 6 with `shamt`=0: `result`=`src_b`, go to DONE.
  - Op 6 with `shamt`≠0: `result`=`src_b`, counter=`shamt`, go to SHIFT.
- **SHIFT**
  - Each cycle `result` shifts by one bit.
  - Left: shift in 0.
  - Right, `shift_ari`=1: shift in the current MSB.
  - Right, `shift_ari`=0: shift in 0.
  - Counter decrements each cycle; at counter==1 the last shift happens and the unit goes to DONE.
  - `in_ready`=0 during SHIFT.
- **DONE**
  - `out_valid`=1; `result` and flags are held stable.
  - On `out_ready`: go to IDLE.
  - No new command is accepted in the same cycle.
- **Ops**
  - AND/OR/XOR/NOR: bitwise on `src_a`, `src_b`.
  - LUI: `{src_b[15:0],16'h0000}`.
  - add: `src_a+src_b`, mod 2^32.
  - sub: `src_a-src_b`, mod 2^32.
  - Op 9: `result`=1 if `src_a`<`src_b` (signed, or unsigned when `do_unsigned`=1), else 0.
  - nop: 0.
  - Illegal ops: `result`=0, `illegal`=1.
- **Flags**
  - `overflow`=1 only for op 7/8 with `do_unsigned`=0 and signed overflow; 0 for all other ops.
  - `zero` is updated with every `result` write, including each shift step.
  - `illegal` is cleared on every new accept.
- **Reset** (any state, including mid-SHIFT or DONE awaiting `out_ready`):
  - State goes to IDLE; `out_valid`=0, `result`=0, `overflow`=0, `zero`=0, `illegal`=0, counter=0.
  - An in-flight command is discarded and no result is emitted.

## Timing
- Non-shift op, or shift with `shamt`=0: accepted in cycle N; `out_valid`=1 in cycle N+1.
- Shift with `shamt`=k (1–31): `out_valid` in cycle N+k+1.
- Minimum throughput: one op per 2 cycles. Next accept is no earlier than the cycle after the `out_ready` handshake.
- `in_ready` is a pure function of state. `out_valid` is registered. No combinational path from `out_ready` to `in_ready` within a cycle.
- `out_ready` held low: DONE persists indefinitely with outputs stable.
- `in_valid` is ignored outside IDLE; the upstream stage must hold the command.

## Test plan
- Add overflow: op 7, `src_a`=7FFFFFFF, `src_b`=1, `do_unsigned`=0 → one cycle later `result`=80000000, `overflow`=1, `zero`=0. Same with `do_unsigned`=1 → `overflow`=0.
- Sub to zero: op 8, `src_a`=`src_b`=12345678 → `result`=0, `zero`=1. Op 9 with `src_a`=FFFFFFFF, `src_b`=1 → `result`=1 when signed, 0 when `do_unsigned`=1.
- Arithmetic right shift: op 6, `src_b`=80000000, `shamt`=4, dir=1, ari=1 → `out_valid` after 5 cycles with `result`=F8000000. Same with ari=0 → 08000000. `in_ready`=0 throughout.
- Shift edge cases: left `shamt`=31, `src_b`=1 → 80000000 after 32 cycles; `shamt`=0 → `src_b` unchanged after 1 cycle.
- Backpressure and illegal op: hold `out_ready`=0 for 10 cycles with LUI `src_b`=0000ABCD → `result` stays ABCD0000 and `in_ready`=0. Op 12 → `result`=0, `illegal`=1.
- Reset mid-shift: assert `rst` in cycle 3 of a `shamt`=20 shift → next cycle all outputs are 0 and `in_ready`=1. No `out_valid` pulse ever appears for the aborted command.
